// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port GPR file with a per-register busy scoreboard and a PC.
//   clk, rst_n                    : clock, async active-low reset
//   rd_en/rd_addr                 : NUM_RD read requests, packed indices
//   rd_data/rd_valid/rd_busy      : registered read results (1-cycle latency)
//   wr_en/wr_addr/wr_data         : single GPR write port (also clears busy)
//   bsy_set/bsy_addr              : mark a destination register pending
//   pc_wen/pc_wdata/pc            : program counter
// x0 is hardwired to zero and is never reported busy.

module regfile_mp_rdport #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] old_data,
  input  logic                  old_busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  bsy_set,
  input  logic [ADDR_WIDTH-1:0] bsy_addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  busy
);
  logic                  zero_idx, hit_wr, hit_set;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic                  nxt_busy;

  assign zero_idx = (addr == '0);
  // Forward only when enabled; a collision without bypass returns the old value.
  assign hit_wr   = (BYPASS != 0) && wr_en && (wr_addr == addr) && !zero_idx;
  assign hit_set  = bsy_set && (bsy_addr == addr);

  always_comb begin
    nxt_data = old_data;
    nxt_busy = old_busy;
    if (zero_idx) begin
      nxt_data = '0;
      nxt_busy = 1'b0;
    end else if (hit_wr) begin
      // The write retires the old producer; only a same-edge set keeps it pending.
      nxt_data = wr_data;
      nxt_busy = hit_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        data <= nxt_data;
        busy <= nxt_busy;
      end
    end
  end
endmodule

module regfile_mp #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_RD     = 2,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] PC_RESET   = 32'h8000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_valid,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         bsy_set,
  input  logic [ADDR_WIDTH-1:0]        bsy_addr,
  input  logic                         pc_wen,
  input  logic [DATA_WIDTH-1:0]        pc_wdata,
  output logic [DATA_WIDTH-1:0]        pc
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0][DATA_WIDTH-1:0] gpr;
  logic [NREG-1:0]                 busy_q;
  logic [DATA_WIDTH-1:0]           pc_q;

  // Index 0 is never written, so gpr[0] stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) gpr <= '0;
    else if (wr_en && wr_addr != '0) gpr[wr_addr] <= wr_data;
  end

  // Set is issued after clear so a same-index set wins (newer producer).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else begin
      if (wr_en) busy_q[wr_addr] <= 1'b0;
      if (bsy_set && bsy_addr != '0) busy_q[bsy_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pc_q <= PC_RESET;
    else if (pc_wen) pc_q <= pc_wdata;
  end
  assign pc = pc_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    regfile_mp_rdport #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .BYPASS(BYPASS)
    ) u_rd (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (rd_en[i]),
      .addr    (a),
      .old_data(gpr[a]),
      .old_busy(busy_q[a]),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .bsy_set (bsy_set),
      .bsy_addr(bsy_addr),
      .data    (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .valid   (rd_valid[i]),
      .busy    (rd_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  typedef struct packed {logic [31:0] d; logic b;} exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic        wr_en = 0, bsy_set = 0, pc_wen = 0;
  logic [4:0]  wr_addr = '0, bsy_addr = '0;
  logic [31:0] wr_data = '0, pc_wdata = '0;

  logic [63:0] rd_data1, rd_data0;
  logic [1:0]  rd_valid1, rd_valid0, rd_busy1, rd_busy0;
  logic [31:0] pc1, pc0;

  int n_vec = 0, n_err = 0;
  exp_t q10[$], q11[$], q00[$], q01[$];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bsy_set(bsy_set), .bsy_addr(bsy_addr),
    .pc_wen(pc_wen), .pc_wdata(pc_wdata), .pc(pc1));

  regfile_mp #(.BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .bsy_set(bsy_set), .bsy_addr(bsy_addr),
    .pc_wen(pc_wen), .pc_wdata(pc_wdata), .pc(pc0));

  function automatic exp_t mk(input logic [31:0] d, input logic b);
    exp_t e;
    e.d = d;
    e.b = b;
    return e;
  endfunction

  function void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endfunction

  function void cmp(input string nm, input logic [31:0] gd, input logic gb, input exp_t e);
    chk({nm, ".data"}, {32'h0, gd}, {32'h0, e.d});
    chk({nm, ".busy"}, {63'h0, gb}, {63'h0, e.b});
  endfunction

  // Monitor: every presented read result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid1[0]) begin
      if (q10.size() == 0) chk("b1p0 unexpected valid", 64'd1, 64'd0);
      else cmp("b1p0", rd_data1[31:0], rd_busy1[0], q10.pop_front());
    end
    if (rd_valid1[1]) begin
      if (q11.size() == 0) chk("b1p1 unexpected valid", 64'd1, 64'd0);
      else cmp("b1p1", rd_data1[63:32], rd_busy1[1], q11.pop_front());
    end
    if (rd_valid0[0]) begin
      if (q00.size() == 0) chk("b0p0 unexpected valid", 64'd1, 64'd0);
      else cmp("b0p0", rd_data0[31:0], rd_busy0[0], q00.pop_front());
    end
    if (rd_valid0[1]) begin
      if (q01.size() == 0) chk("b0p1 unexpected valid", 64'd1, 64'd0);
      else cmp("b0p1", rd_data0[63:32], rd_busy0[1], q01.pop_front());
    end
  end

  // One cycle of stimulus, driven at negedge so it is stable at the next posedge.
  // e1x: expected result for the BYPASS=1 instance, e0x: for BYPASS=0, port x.
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic bs, input logic [4:0] ba,
                      input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                      input exp_t e10, input exp_t e11, input exp_t e00, input exp_t e01);
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd;
    bsy_set = bs; bsy_addr = ba;
    rd_en = re; rd_addr = {ra1, ra0};
    pc_wen = 0;
    if (re[0]) begin q10.push_back(e10); q00.push_back(e00); end
    if (re[1]) begin q11.push_back(e11); q01.push_back(e01); end
  endtask

  task automatic idle();
    exp_t z;
    z = mk(32'h0, 1'b0);
    step(0, 5'd0, 32'h0, 0, 5'd0, 2'b00, 5'd0, 5'd0, z, z, z, z);
  endtask

  initial begin
    exp_t z, e;
    z = mk(32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset pc", {32'h0, pc1}, 64'h8000_0000);
    chk("reset rd_data", {rd_data1}, 64'h0);
    chk("reset valid/busy", {60'h0, rd_valid1, rd_busy1}, 64'h0);
    @(negedge clk);
    rst_n = 1;

    // Read of an untouched register returns zero.
    step(0, 5'd0, 32'h0, 0, 5'd0, 2'b01, 5'd5, 5'd0, z, z, z, z);
    step(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 2'b00, 5'd0, 5'd0, z, z, z, z);
    // Dual-port read of the same index.
    e = mk(32'hDEAD_BEEF, 1'b0);
    step(0, 5'd0, 32'h0, 0, 5'd0, 2'b11, 5'd5, 5'd5, e, e, e, e);
    @(posedge clk); #1;
    chk("dual valid", {62'h0, rd_valid1}, 64'd3);
    idle();
    @(posedge clk); #1;
    chk("valid drops", {62'h0, rd_valid1}, 64'd0);
    chk("data held", {32'h0, rd_data1[31:0]}, 64'hDEAD_BEEF);

    // x0: writes discarded, including a same-edge write.
    step(1, 5'd0, 32'h1234, 0, 5'd0, 2'b01, 5'd0, 5'd0, z, z, z, z);
    step(0, 5'd0, 32'h0, 1, 5'd0, 2'b11, 5'd0, 5'd0, z, z, z, z);

    // Forwarding on a write/read collision.
    step(1, 5'd7, 32'h1, 0, 5'd0, 2'b00, 5'd0, 5'd0, z, z, z, z);
    step(1, 5'd7, 32'h2, 0, 5'd0, 2'b01, 5'd7, 5'd0,
         mk(32'h2, 0), z, mk(32'h1, 0), z);
    step(0, 5'd0, 32'h0, 0, 5'd0, 2'b10, 5'd0, 5'd7,
         z, mk(32'h2, 0), z, mk(32'h2, 0));

    // Busy scoreboard.
    step(0, 5'd0, 32'h0, 1, 5'd9, 2'b00, 5'd0, 5'd0, z, z, z, z);
    step(0, 5'd0, 32'h0, 0, 5'd0, 2'b01, 5'd9, 5'd0,
         mk(32'h0, 1), z, mk(32'h0, 1), z);
    step(1, 5'd9, 32'h99, 1, 5'd9, 2'b10, 5'd0, 5'd9,
         z, mk(32'h99, 1), z, mk(32'h0, 1));
    step(0, 5'd0, 32'h0, 0, 5'd0, 2'b11, 5'd9, 5'd9,
         mk(32'h99, 1), mk(32'h99, 1), mk(32'h99, 1), mk(32'h99, 1));
    step(1, 5'd9, 32'hAA, 0, 5'd0, 2'b01, 5'd9, 5'd0,
         mk(32'hAA, 0), z, mk(32'h99, 1), z);
    step(0, 5'd0, 32'h0, 0, 5'd0, 2'b11, 5'd9, 5'd0,
         mk(32'hAA, 0), z, mk(32'hAA, 0), z);
    idle();

    // PC load, then asynchronous reset mid-cycle.
    @(negedge clk);
    pc_wen = 1; pc_wdata = 32'h8000_0010;
    @(posedge clk); #1;
    chk("pc load", {32'h0, pc1}, 64'h8000_0010);
    idle();
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("async pc", {32'h0, pc1}, 64'h8000_0000);
    chk("async rd_data", rd_data1, 64'h0);
    chk("async rd_valid", {62'h0, rd_valid1}, 64'd0);
    @(negedge clk);
    rst_n = 1;
    step(0, 5'd0, 32'h0, 0, 5'd0, 2'b11, 5'd5, 5'd9, z, z, z, z);
    step(0, 5'd0, 32'h0, 0, 5'd0, 2'b01, 5'd7, 5'd0, z, z, z, z);
    idle();
    idle();

    chk("queues drained", {32'h0, 32'(q10.size() + q11.size() + q00.size() + q01.size())}, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
